// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: trigger-level encodings, error bit
// positions inside the per-character error field, and default sizing.
// Pure declarations; no state, no latency, no flow control.
package uart_pkg;

  localparam int UART_DEPTH_DEF    = 16;
  localparam int UART_TO_CHARS_DEF = 4;

  // Bit positions within the {BI, FE, PE} error field
  localparam int ERR_BI = 2;
  localparam int ERR_FE = 1;
  localparam int ERR_PE = 0;

  typedef enum logic [1:0] {
    TL_1  = 2'b00,
    TL_4  = 2'b01,
    TL_8  = 2'b10,
    TL_14 = 2'b11
  } rx_tl_e;

  // Occupancy at which the receive trigger fires for a given RXFIFTL code
  function automatic int unsigned rx_trig_thresh(input logic [1:0] tl);
    int unsigned t;
    case (tl)
      TL_1:    t = 1;
      TL_4:    t = 4;
      TL_8:    t = 8;
      default: t = 14;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Saturating character-timeout counter: counts char_tick pulses while idle.
// Latency: expired rises on the edge of the TO_CHARS-th tick; drops the edge after restart.
// Backpressure: none; restart and inactivity force the count back to zero.
module uart_rx_timeout
  import uart_pkg::*;
#(
  parameter int TO_CHARS = UART_TO_CHARS_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  input  logic active,
  input  logic char_tick,
  output logic expired
);

  localparam int TW = $clog2(TO_CHARS + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TO_CHARS);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: cleared on any access or when nothing is waiting, saturates at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !active) begin
      cnt_d = '0;
    end else if (char_tick && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO holding characters with their BI/FE/PE bits.
// Latency: first-word fall-through; a pushed character is visible one cycle after its push edge.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and sets sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_DEPTH_DEF,
  parameter int DATA_W   = 8,
  parameter int ERR_W    = 3,
  parameter int TO_CHARS = UART_TO_CHARS_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FIFOEN,
  input  logic                     RXCLR,
  input  logic [1:0]               RXFIFTL,
  input  logic                     rx_wr_en,
  input  logic [DATA_W-1:0]        rx_wr_data,
  input  logic [ERR_W-1:0]         rx_wr_err,
  input  logic                     rx_rd_en,
  input  logic                     lsr_rd,
  input  logic                     char_tick,
  output logic [DATA_W-1:0]        rx_rd_data,
  output logic [ERR_W-1:0]         rx_rd_err,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic                     rx_trigger,
  output logic                     rx_timeout,
  output logic                     rx_overrun,
  output logic                     rx_err_in_fifo
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP_FIFO = CW'(DEPTH);
  localparam logic [CW-1:0] CAP_HOLD = CW'(1);

  logic [ERR_W+DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d, err_cnt_q, err_cnt_d;
  logic              overrun_q, overrun_d;
  logic              fifoen_q;

  logic [CW-1:0]     cap;
  logic              is_empty, is_full, clr;
  logic              do_pop, do_push, ovr_set;
  logic              head_err_nz, wr_err_nz, to_expired;
  logic [ERR_W-1:0]  head_err;
  logic [DATA_W-1:0] head_data;

  assign {head_err, head_data} = mem_q[rd_ptr_q];
  assign head_err_nz = (head_err != '0);
  assign wr_err_nz   = (rx_wr_err != '0);

  // Access decode; a mode change acts as an implicit clear that swallows push and pop
  always_comb begin
    cap      = FIFOEN ? CAP_FIFO : CAP_HOLD;
    is_empty = (count_q == '0);
    is_full  = (count_q == cap);
    clr      = RXCLR | (FIFOEN != fifoen_q);
    do_pop   = rx_rd_en & ~is_empty & ~clr;
    // Full still accepts when the head leaves in the same cycle
    do_push  = rx_wr_en & ~clr & (~is_full | do_pop);
    ovr_set  = rx_wr_en & ~clr & is_full & ~rx_rd_en;
  end

  // Pointer, occupancy, error-count and overrun next state
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      // Holding-register mode keeps both pointers parked at entry 0
      if (do_pop) begin
        rd_ptr_d = FIFOEN ? rd_ptr_q + 1'b1 : '0;
      end
      if (do_push) begin
        wr_ptr_d = FIFOEN ? wr_ptr_q + 1'b1 : '0;
      end
      count_d   = count_q + CW'(do_push) - CW'(do_pop);
      err_cnt_d = err_cnt_q + CW'(do_push & wr_err_nz) - CW'(do_pop & head_err_nz);
    end
    // A new overrun outranks the LSR read that would clear it
    overrun_d = ovr_set | (overrun_q & ~lsr_rd);
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
      fifoen_q  <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
      fifoen_q  <= FIFOEN;
    end
  end

  // Character storage; contents are only meaningful below count_q, so no reset
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {rx_wr_err, rx_wr_data};
    end
  end

  uart_rx_timeout #(
    .TO_CHARS (TO_CHARS)
  ) u_timeout (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .restart   (clr | rx_wr_en | rx_rd_en),
    .active    (~is_empty),
    .char_tick (char_tick),
    .expired   (to_expired)
  );

  assign rx_rd_data     = is_empty ? '0 : head_data;
  assign rx_rd_err      = is_empty ? '0 : head_err;
  assign rx_count       = count_q;
  assign rx_empty       = is_empty;
  assign rx_full        = is_full;
  assign rx_trigger     = FIFOEN ? (32'(count_q) >= rx_trig_thresh(RXFIFTL)) : ~is_empty;
  assign rx_timeout     = FIFOEN & ~is_empty & to_expired;
  assign rx_overrun     = overrun_q;
  assign rx_err_in_fifo = (err_cnt_q != '0) & FIFOEN;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic; popped data checked by a monitor.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int TO    = 4;

  typedef logic [10:0] ent_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       FIFOEN = 1'b0;
  logic       RXCLR = 1'b0;
  logic [1:0] RXFIFTL = 2'b00;
  logic       rx_wr_en = 1'b0;
  logic [7:0] rx_wr_data = '0;
  logic [2:0] rx_wr_err = '0;
  logic       rx_rd_en = 1'b0;
  logic       lsr_rd = 1'b0;
  logic       char_tick = 1'b0;
  logic [7:0] rx_rd_data;
  logic [2:0] rx_rd_err;
  logic [4:0] rx_count;
  logic       rx_empty, rx_full, rx_trigger, rx_timeout, rx_overrun, rx_err_in_fifo;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .ERR_W(3), .TO_CHARS(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .FIFOEN(FIFOEN), .RXCLR(RXCLR), .RXFIFTL(RXFIFTL),
    .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_wr_err(rx_wr_err),
    .rx_rd_en(rx_rd_en), .lsr_rd(lsr_rd), .char_tick(char_tick),
    .rx_rd_data(rx_rd_data), .rx_rd_err(rx_rd_err), .rx_count(rx_count),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_trigger(rx_trigger),
    .rx_timeout(rx_timeout), .rx_overrun(rx_overrun), .rx_err_in_fifo(rx_err_in_fifo)
  );

  // Reference model state
  ent_t mq[$];
  ent_t exp_q[$];
  bit   m_fifoen = 0;
  bit   m_ovr = 0;
  int   m_to = 0;
  bit   mon_clr = 0;
  int   thr[4] = '{1, 4, 8, 14};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic int model_errs();
    int n = 0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) n++;
    return n;
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled
  function automatic void model_step();
    int cap = FIFOEN ? DEPTH : 1;
    bit clr = RXCLR || (FIFOEN != m_fifoen);
    bit was_empty = (mq.size() == 0);
    bit ovr_set = 0;
    if (clr) begin
      mq.delete();
    end else begin
      bit full = (mq.size() == cap);
      bit pop = rx_rd_en && !was_empty;
      if (rx_wr_en && full && !rx_rd_en) ovr_set = 1;
      if (pop) void'(mq.pop_front());
      if (rx_wr_en && (!full || pop)) mq.push_back({rx_wr_err, rx_wr_data});
    end
    if (ovr_set) m_ovr = 1;
    else if (lsr_rd) m_ovr = 0;
    if (clr || rx_wr_en || rx_rd_en || was_empty) m_to = 0;
    else if (char_tick && m_to < TO) m_to++;
    m_fifoen = FIFOEN;
  endfunction

  function automatic void check_flags();
    int cap = FIFOEN ? DEPTH : 1;
    int sz = mq.size();
    chk("count", int'(rx_count), sz);
    chk("empty", int'(rx_empty), int'(sz == 0));
    chk("full", int'(rx_full), int'(sz == cap));
    chk("trigger", int'(rx_trigger), FIFOEN ? int'(sz >= thr[RXFIFTL]) : int'(sz != 0));
    chk("timeout", int'(rx_timeout), int'(FIFOEN && sz != 0 && m_to == TO));
    chk("overrun", int'(rx_overrun), int'(m_ovr));
    chk("err_in_fifo", int'(rx_err_in_fifo), int'(FIFOEN && model_errs() != 0));
    if (sz == 0) chk("empty_head", int'({rx_rd_err, rx_rd_data}), 0);
  endfunction

  // One clock of stimulus, entered and left at posedge+1
  task automatic cyc(input bit wr, input logic [7:0] d, input logic [2:0] e,
                     input bit rd, input bit lsr, input bit tick, input bit clr);
    rx_wr_en = wr; rx_wr_data = d; rx_wr_err = e;
    rx_rd_en = rd; lsr_rd = lsr; char_tick = tick; RXCLR = clr;
    mon_clr = clr || (FIFOEN != m_fifoen);
    if (!mon_clr && rd && mq.size() != 0) exp_q.push_back(mq[0]);
    @(posedge CLK);
    model_step();
    #1;
    check_flags();
  endtask

  task automatic idle();
    cyc(0, 8'h00, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] e);
    cyc(1, d, e, 0, 0, 0, 0);
  endtask

  task automatic pop();
    cyc(0, 8'h00, 3'b000, 1, 0, 0, 0);
  endtask

  // Asynchronous reset away from the clock edge, checked immediately
  task automatic do_reset();
    #3;
    rx_wr_en = 0; rx_rd_en = 0; lsr_rd = 0; char_tick = 0; RXCLR = 0;
    RST_N = 0;
    #1;
    mq.delete(); exp_q.delete();
    m_ovr = 0; m_to = 0; m_fifoen = 0; mon_clr = 0;
    check_flags();
    chk("reset_count", int'(rx_count), 0);
    chk("reset_empty", int'(rx_empty), 1);
    @(negedge CLK);
    RST_N = 1;
    @(posedge CLK);
    model_step();
    #1;
    check_flags();
  endtask

  // Monitor: compare the head whenever the host pops a non-empty FIFO
  always @(negedge CLK) begin
    if (RST_N && rx_rd_en && !rx_empty && !mon_clr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_data: DUT popped %0h with no expected entry (t=%0t)",
                 {rx_rd_err, rx_rd_data}, $time);
      end else begin
        ent_t ex;
        ex = exp_q.pop_front();
        chk("pop_data", int'({rx_rd_err, rx_rd_data}), int'(ex));
      end
    end
  end

  initial begin
    logic [2:0] e;
    do_reset();

    // Trigger at level 4 and in-order readout
    FIFOEN = 1; RXFIFTL = TL_4;
    idle();
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 3'b000);
    chk("tp_trigger4", int'(rx_trigger), 1);
    chk("tp_count4", int'(rx_count), 4);
    for (int i = 0; i < 4; i++) pop();
    chk("tp_empty_after", int'(rx_empty), 1);

    // Fill, overflow, LSR clear, push+pop at full
    for (int i = 0; i < DEPTH; i++) push(8'($urandom), 3'b000);
    chk("tp_full", int'(rx_full), 1);
    push(8'hEE, 3'b000);
    chk("tp_overrun_set", int'(rx_overrun), 1);
    chk("tp_count_full", int'(rx_count), DEPTH);
    cyc(0, 8'h00, 3'b000, 0, 1, 0, 0);
    chk("tp_overrun_clr", int'(rx_overrun), 0);
    cyc(1, 8'h77, 3'b000, 1, 0, 0, 0);
    chk("tp_pushpop_full_ovr", int'(rx_overrun), 0);
    chk("tp_pushpop_full_cnt", int'(rx_count), DEPTH);
    for (int i = 0; i < DEPTH; i++) pop();

    // Error-in-FIFO tracking
    e = 3'b000; e[ERR_FE] = 1'b1;
    push(8'h55, e);
    push(8'h66, 3'b000);
    chk("tp_err_in", int'(rx_err_in_fifo), 1);
    pop();
    chk("tp_err_gone", int'(rx_err_in_fifo), 0);
    pop();

    // Character timeout
    push(8'h10, 3'b000);
    push(8'h11, 3'b000);
    for (int i = 0; i < TO; i++) cyc(0, 8'h00, 3'b000, 0, 0, 1, 0);
    chk("tp_timeout", int'(rx_timeout), 1);
    pop();
    chk("tp_timeout_drop", int'(rx_timeout), 0);
    for (int i = 0; i < TO; i++) cyc(0, 8'h00, 3'b000, 0, 0, 1, 0);
    pop();

    // Clear with simultaneous push
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i), 3'b000);
    cyc(1, 8'h99, 3'b000, 0, 0, 0, 1);
    chk("tp_clr_count", int'(rx_count), 0);
    chk("tp_clr_empty", int'(rx_empty), 1);

    // Mode change clears, then holding-register overrun
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 3'b000);
    FIFOEN = 0;
    idle();
    chk("tp_mode_clr", int'(rx_count), 0);
    push(8'hA1, 3'b000);
    push(8'hA2, 3'b000);
    chk("tp_hold_ovr", int'(rx_overrun), 1);
    chk("tp_hold_full", int'(rx_full), 1);
    cyc(0, 8'h00, 3'b000, 1, 1, 0, 0);

    // Reset in the middle of traffic
    FIFOEN = 1;
    idle();
    for (int i = 0; i < 3; i++) push(8'($urandom), 3'b101);
    do_reset();

    // Randomized traffic with fill/drain phases
    for (int i = 0; i < 3000; i++) begin
      int ph = (i / 100) % 3;
      int wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      int rp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      if ($urandom_range(0, 199) == 0) FIFOEN = ~FIFOEN;
      if ($urandom_range(0, 99) == 0) RXFIFTL = 2'($urandom);
      e = 3'b000;
      if ($urandom_range(0, 3) == 0) begin
        e[ERR_BI] = 1'($urandom); e[ERR_FE] = 1'($urandom); e[ERR_PE] = 1'($urandom);
      end
      cyc($urandom_range(0, 99) < wp, 8'($urandom), e,
          $urandom_range(0, 99) < rp, $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    end

    idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 16550-style receive FIFO for the UART. It sits downstream of the FIFO control register and upstream of the line-status and interrupt logic.
- Stores received characters together with their per-character error bits (BI/FE/PE).
- Consumes FIFOEN, RXCLR and RXFIFTL from the control register.
- Produces data-ready, trigger-level, character-timeout, overrun and error-in-FIFO indications for the host and interrupt logic.

Parameters:
- DEPTH, 16, storage entries in FIFO mode; power of two, >= 16.
- DATA_W, 8, character width.
- ERR_W, 3, error bits per entry: {BI, FE, PE}.
- TO_CHARS, 4, character times with no push or pop before timeout asserts.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FIFOEN  in  1  1 = FIFO mode (DEPTH entries); 0 = single holding register.
- RXCLR  in  1  single-cycle synchronous clear request.
- RXFIFTL  in  2  trigger level select.
- rx_wr_en  in  1  push strobe from the deserializer.
- rx_wr_data  in  DATA_W  received character.
- rx_wr_err  in  ERR_W  error bits for that character.
- rx_rd_en  in  1  pop strobe from the host read of RBR.
- lsr_rd  in  1  host read of LSR; clears the overrun flag.
- char_tick  in  1  one-cycle pulse per character time, from the baud generator.
- rx_rd_data  out  DATA_W  head character (first-word fall-through); 0 when empty.
- rx_rd_err  out  ERR_W  head entry error bits; 0 when empty.
- rx_count  out  $clog2(DEPTH)+1  occupancy.
- rx_empty  out  1  occupancy == 0; the inverse is LSR.DR.
- rx_full  out  1  occupancy == capacity.
- rx_trigger  out  1  trigger level reached.
- rx_timeout  out  1  character-timeout indication.
- rx_overrun  out  1  sticky overrun (LSR.OE).
- rx_err_in_fifo  out  1  at least one stored entry has a nonzero error field (LSR bit 7).

Behaviour:
- Reset (RST_N low, asynchronous):
  - rd_ptr = wr_ptr = count = 0, err_cnt = 0, timeout counter = 0, rx_overrun = 0, fifoen_q = 0.
  - Outputs: rx_empty = 1; rx_full, rx_trigger, rx_timeout and rx_err_in_fifo = 0; rx_rd_data and rx_rd_err = 0.
  - The memory array is not reset.
- Capacity is DEPTH when FIFOEN = 1, otherwise 1.
- Mode change: fifoen_q registers FIFOEN every cycle. When FIFOEN != fifoen_q, an implicit clear occurs that cycle.
- Clear (RXCLR or mode change):
  - Next edge: pointers, count, err_cnt and timeout counter go to 0.
  - A push in the same cycle is dropped and does not set overrun.
  - A pop in the same cycle is ignored.
  - rx_overrun is NOT cleared.
- Push (rx_wr_en, no clear):
  - Not full: write {err, data} at wr_ptr; wr_ptr+1 (wraps modulo DEPTH; modulo 1 in non-FIFO mode, so pointers stay 0); count+1.
  - Full with rx_rd_en the same cycle: pop and push both occur; count unchanged; no overrun.
  - Full without pop: character discarded; rx_overrun <= 1.
- Pop (rx_rd_en):
  - Not empty: rd_ptr+1, count-1.
  - Empty: ignored. A simultaneous push still occurs; there is no bypass, so data is visible the next cycle.
- Read latency: rx_rd_data and rx_rd_err show mem[rd_ptr] combinationally. A pushed character is visible one cycle after the push edge.
- Overrun: set on discarded push. Cleared by lsr_rd on the next edge. If set and clear coincide, set wins.
- err_cnt tracks stored entries whose err != 0:
  - +1 on an accepted push with nonzero err.
  - -1 on a pop whose head err != 0.
  - Both at once: net 0.
  - rx_err_in_fifo = (err_cnt != 0) & FIFOEN.
- rx_trigger:
  - FIFO mode: count >= threshold, where RXFIFTL 00/01/10/11 maps to 1/4/8/14.
  - Non-FIFO mode: !rx_empty.
  - Combinational from registered count.
- Timeout counter (0..TO_CHARS, saturating):
  - Reset to 0 on any push, pop, clear, or when empty.
  - Otherwise +1 on each char_tick.
  - rx_timeout = FIFOEN & !rx_empty & (counter == TO_CHARS).
  - Drops the cycle after a pop or push edge.
- Simultaneous push and pop at count 0 or count == capacity are handled as above. Count never exceeds capacity and never underflows.

Decomposition:
- Shared package uart_pkg:
  - Trigger-level encodings and thresholds (1/4/8/14).
  - Error bit indices BI = 2, FE = 1, PE = 0.
  - Default DEPTH and TO_CHARS.
- One sub-module, uart_rx_timeout: saturating character-timeout counter.
  - Inputs: CLK, RST_N, restart, active, char_tick.
  - Output: expired.
- Storage, pointers, flags and the error counter stay in uart_rx_fifo.

Test Plan:
- Reset then FIFOEN = 1, RXFIFTL = 01; push 0x41, 0x42, 0x43, 0x44 -> rx_trigger rises the cycle after the 4th push; rx_count = 4; pops return 0x41..0x44 in order; rx_empty = 1 after.
- Push 16 characters, then a 17th with no pop -> rx_full = 1, rx_overrun = 1, 17th lost. Then lsr_rd -> overrun 0. A 17th push with a simultaneous pop -> no overrun, count stays 16.
- Push 0x55 with err = 3'b010, then 0x66 clean -> rx_err_in_fifo = 1; stays 1 after popping 0x66? No: pop 0x55 -> rx_err_in_fifo = 0 the next cycle.
- Push 2 characters, 4 char_tick pulses with no access -> rx_timeout = 1 after the 4th tick. Pop -> rx_timeout = 0 next cycle, counter restarts.
- Push 5 characters, pulse RXCLR together with a push -> rx_count = 0, rx_empty = 1, rx_overrun unchanged. Toggle FIFOEN 1->0 with 3 entries stored -> cleared; capacity 1; second push without pop sets overrun.
- Assert RST_N low mid-stream, asynchronous to CLK -> all flags and outputs at reset values immediately; rx_count = 0.
